// File: rtl/mic_i2s_capture_if.sv
// Sample read-side bus between the mic capture FIFO and the DMA master.
// Latency: pure wiring, no storage.
// Backpressure: the consumer pops with sample_ack while read_ready is high.
interface mic_i2s_capture_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic [31:0]                   mic_data;
  logic                          read_ready;
  logic                          sample_ack;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          overflow;

  modport master (
    output mic_data,
    output read_ready,
    output level,
    output overflow,
    input  sample_ack
  );

  modport slave (
    input  mic_data,
    input  read_ready,
    input  level,
    input  overflow,
    output sample_ack
  );
endinterface

// File: rtl/mic_i2s_capture.sv
// I2S master (SCK/WS generation) for a MEMS mic, MSB-first deserializer with sign extension, show-ahead sample FIFO.
// Latency: sample enters the FIFO 1 CLK after the SCK rising edge of its last bit; a pop is visible 1 CLK after the ack.
// Backpressure: none toward the mic; a sample arriving at a full FIFO is dropped and sets sticky overflow.
// Build option MIC_STEREO_EN: capture left and right slots; when undefined only the left slot is captured.
module mic_i2s_capture #(
  parameter int CLK_DIV     = 4,
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              enable,
  output logic              MIC_SCK,
  output logic              MIC_WS,
  input  logic              MIC_SD,
  mic_i2s_capture_if.master rd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [5:0]             per_q, per_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic                   push_q, push_d;

  logic [31:0]            mem_q [FIFO_DEPTH];
  logic [31:0]            mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   ovf_clr;
  logic                   slot_act;
  logic [5:0]             per_nxt;
  logic                   pop;
  logic                   full;
  logic                   wr;
  logic                   drop;
  logic [31:0]            word_ext;

  // Sign-extend the assembled slot word from its top valid bit to 32 bits.
  function automatic logic [31:0] sext(input logic [SAMPLE_BITS-1:0] v);
    logic [31:0] r;
    r = {32{v[SAMPLE_BITS-1]}};
    r[SAMPLE_BITS-1:0] = v;
    return r;
  endfunction

  // Capture FSM: SCK divider, frame period counter, WS and the MSB-first shift register.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sck_d    = sck_q;
    ws_d     = ws_q;
    per_d    = per_q;
    shreg_d  = shreg_q;
    push_d   = 1'b0;
    ovf_clr  = 1'b0;
    per_nxt  = per_q + 6'd1;
`ifdef MIC_STEREO_EN
    slot_act = 1'b1;
`else
    // Right-slot bits are neither shifted nor pushed in the mono build.
    slot_act = ~per_q[5];
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        sck_d = 1'b0;
        ws_d  = 1'b0;
        per_d = '0;
        if (enable) begin
          state_d = RUN;
          ovf_clr = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Partial word is abandoned; the next RUN restarts the frame at p=0.
          state_d = IDLE;
          div_d   = '0;
          sck_d   = 1'b0;
          ws_d    = 1'b0;
          per_d   = '0;
        end else if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            // Rising edge: sample SD for bit k of the current slot.
            if (slot_act && (int'(per_q[4:0]) < SAMPLE_BITS)) begin
              shreg_d = (shreg_q << 1) | SAMPLE_BITS'(MIC_SD);
            end
            if (slot_act && (int'(per_q[4:0]) == SAMPLE_BITS - 1)) begin
              push_d = 1'b1;
            end
          end else begin
            // Falling edge closes period p; WS leads each slot by one period.
            per_d = per_nxt;
            ws_d  = (per_nxt >= 6'd31) && (per_nxt <= 6'd62);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture-side registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      per_q   <= '0;
      shreg_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      per_q   <= per_d;
      shreg_q <= shreg_d;
      push_q  <= push_d;
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push, so full+push+pop keeps the level.
  always_comb begin
    word_ext = sext(shreg_q);
    pop      = rd.sample_ack && (cnt_q != '0);
    full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    wr       = push_q && (!full || pop);
    drop     = push_q && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (wr) begin
      mem_d[wr_ptr_q] = word_ext;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO pointer, occupancy and sticky overflow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; never read while empty, so it needs no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign MIC_SCK       = sck_q;
  assign MIC_WS        = ws_q;
  assign rd.mic_data   = (cnt_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign rd.read_ready = (cnt_q != '0);
  assign rd.level      = cnt_q;
  assign rd.overflow   = ovf_q;

endmodule

// File: tb/tb_mic_i2s_capture.sv
// Bench for mic_i2s_capture: edge-driven mic model feeds a scoreboard queue, a monitor checks the FIFO side every cycle.
// Latency: expected words enter the queue when their last bit is sent; the DUT lands them one CLK later.
// Backpressure: the bench drives sample_ack directly (held low, single pulse, or continuous drain).
module tb_mic_i2s_capture;
  localparam int CLK_DIV     = 2;
  localparam int SAMPLE_BITS = 24;
  localparam int FIFO_DEPTH  = 16;
`ifdef MIC_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif
  localparam int          PUSH_GAP = STEREO ? 128 : 256;
  localparam logic [31:0] SECOND   = STEREO ? 32'h00123456 : 32'h007FFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic mic_sd = 1'b0;
  logic mic_sck, mic_ws;

  mic_i2s_capture_if #(.FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

  mic_i2s_capture #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_BITS(SAMPLE_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .enable (enable),
    .MIC_SCK(mic_sck),
    .MIC_WS (mic_ws),
    .MIC_SD (mic_sd),
    .rd     (rd_if)
  );

  always #5 clk = ~clk;

  // Words the mic sends per frame (cycled by frame index) and their hand sign-extended images.
  logic [23:0] l_raw [4] = '{24'h800001, 24'h7FFFFF, 24'h000000, 24'hA5A5A5};
  logic [31:0] l_exp [4] = '{32'hFF800001, 32'h007FFFFF, 32'h00000000, 32'hFFA5A5A5};
  logic [23:0] r_raw [4] = '{24'h123456, 24'h800000, 24'hFFFFFF, 24'h0F0F0F};
  logic [31:0] r_exp [4] = '{32'h00123456, 32'hFF800000, 32'hFFFFFFFF, 32'h000F0F0F};

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ws(input int p);
    return (p >= 31) && (p <= 62);
  endfunction

  int          cyc = 0;
  int          mdl_p = 0;
  int          frm = 0;
  int          k;
  logic        sck_prev = 1'b0;
  logic [23:0] w;
  logic        pend_push = 1'b0;
  logic [31:0] pend_word = 32'h0;
  int          n_push = 0;
  int          n_drop = 0;
  int          push_cyc [$];
  logic [31:0] q [$];
  int          lvl;
  logic        pop;
  logic [31:0] tmp;

  always @(posedge clk) cyc <= cyc + 1;

  // Mic model: follows SCK edges, shifts out the frame MSB first, announces each finished word.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      mdl_p    = 0;
      frm      = 0;
      sck_prev = 1'b0;
      mic_sd   = 1'b0;
    end else begin
      if (mic_sck && !sck_prev) begin
        chk("ws_at_rise", {31'b0, mic_ws}, {31'b0, exp_ws(mdl_p)});
        if ((mdl_p % 32 == SAMPLE_BITS - 1) && (mdl_p < 32 || STEREO)) begin
          pend_push = 1'b1;
          pend_word = (mdl_p < 32) ? l_exp[frm % 4] : r_exp[frm % 4];
        end
      end else if (!mic_sck && sck_prev) begin
        mdl_p = (mdl_p + 1) % 64;
        if (mdl_p == 0) frm++;
      end
      sck_prev = mic_sck;
      if (!enable) mdl_p = 0;
      k = mdl_p % 32;
      w = (mdl_p < 32) ? l_raw[frm % 4] : r_raw[frm % 4];
      mic_sd = (k < SAMPLE_BITS) ? w[23 - k] : 1'b1;
    end
  end

  // Monitor: FIFO-side outputs against the scoreboard, then apply this cycle's pop/push.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      q.delete();
      pend_push = 1'b0;
    end else begin
      lvl = q.size();
      chk("level", 32'(rd_if.level), 32'(lvl));
      chk("read_ready", {31'b0, rd_if.read_ready}, 32'(lvl != 0));
      chk("mic_data", rd_if.mic_data, (lvl != 0) ? q[0] : 32'h0);
      pop = rd_if.sample_ack && (lvl != 0);
      if (pend_push) begin
        if (lvl == FIFO_DEPTH && !pop) n_drop++;
        else q.push_back(pend_word);
        n_push++;
        push_cyc.push_back(cyc);
        pend_push = 1'b0;
      end
      if (pop) tmp = q.pop_front();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic got;

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sck"}, {31'b0, mic_sck}, 32'd0);
    chk({tag, "_ws"}, {31'b0, mic_ws}, 32'd0);
    chk({tag, "_data"}, rd_if.mic_data, 32'd0);
    chk({tag, "_ready"}, {31'b0, rd_if.read_ready}, 32'd0);
    chk({tag, "_level"}, 32'(rd_if.level), 32'd0);
    chk({tag, "_ovf"}, {31'b0, rd_if.overflow}, 32'd0);
  endtask

  initial begin
    rd_if.sample_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("rst");

    // Idle with enable low: nothing moves.
    repeat (100) begin
      @(negedge clk);
      chk("idle_sck", {31'b0, mic_sck}, 32'd0);
      chk("idle_ws", {31'b0, mic_ws}, 32'd0);
    end

    // Capture: first rise 2 CLK after RUN, p=23 rise at RUN+94, word lands at RUN+95.
    enable = 1'b1;
    repeat (95) @(negedge clk);
    chk("ready_before_p23", {31'b0, rd_if.read_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_p23", {31'b0, rd_if.read_ready}, 32'd1);
    chk("first_head", rd_if.mic_data, 32'hFF800001);

    // Hold ack low until one sample is dropped.
    got = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (n_drop > 0) begin got = 1'b1; break; end
    end
    chk("wait_first_drop", {31'b0, got}, 32'd1);
    @(negedge clk);
    chk("push_gap_1", 32'(push_cyc[1] - push_cyc[0]), 32'(PUSH_GAP));
    chk("push_gap_2", 32'(push_cyc[2] - push_cyc[1]), 32'(PUSH_GAP));
    chk("full_level", 32'(rd_if.level), 32'd16);
    chk("full_ovf", {31'b0, rd_if.overflow}, 32'd1);
    chk("full_head", rd_if.mic_data, 32'hFF800001);

    // Single ack in the cycle a push lands while full.
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (pend_push) begin got = 1'b1; break; end
    end
    chk("wait_push_for_ack", {31'b0, got}, 32'd1);
    rd_if.sample_ack = 1'b1;
    @(negedge clk);
    rd_if.sample_ack = 1'b0;
    chk("pushpop_level", 32'(rd_if.level), 32'd16);
    chk("pushpop_head", rd_if.mic_data, SECOND);
    chk("pushpop_ovf", {31'b0, rd_if.overflow}, 32'd1);

    // Drop enable mid left slot, drain, then re-enable.
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (mdl_p == 10) begin got = 1'b1; break; end
    end
    chk("wait_p10", {31'b0, got}, 32'd1);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    chk("disabled_sck", {31'b0, mic_sck}, 32'd0);
    rd_if.sample_ack = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_if.level == '0) begin got = 1'b1; break; end
    end
    chk("drained", {31'b0, got}, 32'd1);
    repeat (10) @(negedge clk);
    chk("ovf_kept_idle", {31'b0, rd_if.overflow}, 32'd1);
    enable = 1'b1;
    @(negedge clk);
    chk("ovf_clear_on_run", {31'b0, rd_if.overflow}, 32'd0);
    repeat (94) @(negedge clk);
    chk("restart_ready_before", {31'b0, rd_if.read_ready}, 32'd0);
    @(negedge clk);
    chk("restart_ready_after", {31'b0, rd_if.read_ready}, 32'd1);
    repeat (600) @(negedge clk);

    // Reset mid-frame with three entries buffered.
    rd_if.sample_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (rd_if.level == 5'd3) begin got = 1'b1; break; end
    end
    chk("wait_three", {31'b0, got}, 32'd1);
    repeat (20) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_level", 32'(rd_if.level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
